// File: rtl/ysyx_25020047_pkg.sv
// rtl/ysyx_25020047_pkg.sv - shared encodings for the core sequencer
// State, class and error codes plus the inst_type classifier.
package ysyx_25020047_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEM    = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4,
      S_ERROR  = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      C_ALU,
      C_LOAD,
      C_STORE,
      C_BRANCH,
      C_EBREAK,
      C_ILLEGAL
   } cls_e;

   typedef enum logic [1:0] {
      E_NONE    = 2'b00,
      E_ILLEGAL = 2'b01,
      E_IFU_TO  = 2'b10,
      E_LSU_TO  = 2'b11
   } err_e;

   localparam logic [31:0] IT_EBREAK  = 32'h0000_0004;
   localparam logic [31:0] IT_LUI     = 32'h0000_0010;
   localparam logic [31:0] IT_LB      = 32'h0000_0020;
   localparam logic [31:0] IT_LW      = 32'h0000_0040;
   localparam logic [31:0] IT_SB      = 32'h0000_0080;
   localparam logic [31:0] IT_SW      = 32'h0000_0100;
   localparam logic [31:0] IT_BEQ     = 32'h0000_4000;
   localparam logic [31:0] IT_BNE     = 32'h0000_8000;
   localparam logic [31:0] IT_JAL     = 32'h0010_0000;
   localparam logic [31:0] IT_SH      = 32'h0020_0000;
   localparam logic [31:0] IT_ILLEGAL = 32'hFFFF_FFFF;

   // Anything not listed here (lui, jal, plain ALU ops) behaves as ALU/JUMP.
   function automatic cls_e classify(input logic [31:0] it);
      cls_e c;
      case (it)
         IT_LB, IT_LW:        c = C_LOAD;
         IT_SB, IT_SW, IT_SH: c = C_STORE;
         IT_BEQ, IT_BNE:      c = C_BRANCH;
         IT_EBREAK:           c = C_EBREAK;
         IT_ILLEGAL:          c = C_ILLEGAL;
         default:             c = C_ALU;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ysyx_25020047_wdog.sv
// rtl/ysyx_25020047_wdog.sv - request wait counter
// Shared by FETCH and MEM; expired fires on the cycle the count reaches TIMEOUT.
module ysyx_25020047_wdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Counting this cycle would make the wait equal TIMEOUT.
   assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/ysyx_25020047_ctrl.sv
// rtl/ysyx_25020047_ctrl.sv - multi-cycle FETCH/DECODE/MEM/WB sequencer
// Owns the FSM, the latched instruction class and the perf counters.
module ysyx_25020047_ctrl
   import ysyx_25020047_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req,
   input  logic             ifu_ack,
   output logic             inst_wen,
   input  logic [31:0]      inst_type,
   output logic             lsu_req,
   output logic             lsu_we,
   input  logic             lsu_ack,
   output logic             reg_wen,
   output logic             pc_wen,
   output logic             halt,
   output logic [1:0]       err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   localparam logic [CNT_W-1:0] ONE = 1;

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d;
   err_e             err_q, err_d;
   logic [CNT_W-1:0] cyc_q, ret_q;
   logic             wd_en, wd_clr, wd_expired;
   cls_e             dec_cls;

   assign dec_cls = classify(inst_type);

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      err_d   = err_q;
      wd_en   = 1'b0;
      case (state_q)
         S_FETCH: begin
            wd_en = !ifu_ack;
            if (ifu_ack) begin
               state_d = S_DECODE;
            end else if (wd_expired) begin
               state_d = S_ERROR;
               err_d   = E_IFU_TO;
            end
         end
         S_DECODE: begin
            cls_d = dec_cls;
            case (dec_cls)
               C_EBREAK:        state_d = S_HALT;
               C_ILLEGAL: begin
                  state_d = S_ERROR;
                  err_d   = E_ILLEGAL;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         state_d = S_WB;
            endcase
         end
         S_MEM: begin
            wd_en = !lsu_ack;
            if (lsu_ack) begin
               state_d = S_WB;
            end else if (wd_expired) begin
               state_d = S_ERROR;
               err_d   = E_LSU_TO;
            end
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = state_q;
      endcase
   end

   assign wd_clr = (state_d != state_q);

   ysyx_25020047_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cls_q   <= C_ALU;
         err_q   <= E_NONE;
         cyc_q   <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         err_q   <= err_d;
         if (state_q != S_HALT && state_q != S_ERROR)
            cyc_q <= cyc_q + ONE;
         if (state_q == S_WB)
            ret_q <= ret_q + ONE;
      end
   end

   // Strobes come from the state register; reset masks them so a pending request drops at once.
   assign ifu_req   = !rst && (state_q == S_FETCH);
   assign inst_wen  = ifu_req && ifu_ack;
   assign lsu_req   = !rst && (state_q == S_MEM);
   assign lsu_we    = lsu_req && (cls_q == C_STORE);
   assign pc_wen    = !rst && (state_q == S_WB);
   assign reg_wen   = pc_wen && (cls_q != C_STORE) && (cls_q != C_BRANCH);
   assign halt      = (state_q == S_HALT);
   assign err       = err_q;
   assign cycle_cnt = cyc_q;
   assign instret   = ret_q;
   assign state     = state_q;

endmodule

// File: tb/tb_ysyx_25020047_ctrl.sv
// tb/tb_ysyx_25020047_ctrl.sv - scoreboard bench for the core sequencer
module tb_ysyx_25020047_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ifu_ack, lsu_ack;
   logic [31:0] inst_type;
   logic        ifu_req, inst_wen, lsu_req, lsu_we, reg_wen, pc_wen, halt;
   logic [1:0]  err;
   logic [31:0] cycle_cnt, instret;
   logic [2:0]  state;

   logic        rst_b, ifu_ack_b, lsu_ack_b;
   logic [31:0] inst_type_b;
   logic        ifu_req_b, inst_wen_b, lsu_req_b, lsu_we_b, reg_wen_b, pc_wen_b, halt_b;
   logic [1:0]  err_b;
   logic [15:0] cycle_cnt_b, instret_b;
   logic [2:0]  state_b;

   ysyx_25020047_ctrl dut_a (
      .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_ack(ifu_ack), .inst_wen(inst_wen),
      .inst_type(inst_type), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack),
      .reg_wen(reg_wen), .pc_wen(pc_wen), .halt(halt), .err(err),
      .cycle_cnt(cycle_cnt), .instret(instret), .state(state)
   );

   ysyx_25020047_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst_b), .ifu_req(ifu_req_b), .ifu_ack(ifu_ack_b), .inst_wen(inst_wen_b),
      .inst_type(inst_type_b), .lsu_req(lsu_req_b), .lsu_we(lsu_we_b), .lsu_ack(lsu_ack_b),
      .reg_wen(reg_wen_b), .pc_wen(pc_wen_b), .halt(halt_b), .err(err_b),
      .cycle_cnt(cycle_cnt_b), .instret(instret_b), .state(state_b)
   );

   wire [7:0] obs   = {state, ifu_req, lsu_req, lsu_we, reg_wen, pc_wen};
   wire [7:0] obs_b = {state_b, ifu_req_b, lsu_req_b, lsu_we_b, reg_wen_b, pc_wen_b};

   typedef struct packed {
      logic mem;
      logic we;
      logic rw;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          exp_ret, exp_cyc;
   logic [31:0] mix [10] = '{32'h1, 32'h10, 32'h20, 32'h40, 32'h80,
                             32'h100, 32'h200000, 32'h4000, 32'h8000, 32'h100000};

   function automatic exp_t model(input logic [31:0] it);
      exp_t e;
      logic ld, st, br;
      ld = (it == 32'h20) || (it == 32'h40);
      st = (it == 32'h80) || (it == 32'h100) || (it == 32'h200000);
      br = (it == 32'h4000) || (it == 32'h8000);
      e.mem = ld || st;
      e.we  = st;
      e.rw  = !(st || br);
      return e;
   endfunction

   task automatic do_reset();
      rst = 1'b1; ifu_ack = 1'b0; lsu_ack = 1'b0; inst_type = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_ret = 0;
      exp_cyc = 0;
   endtask

   // Entered just after a negedge in FETCH; leaves just after the negedge back in FETCH.
   task automatic run_inst(input logic [31:0] it, input int wait_n, input bit stray);
      exp_t cur, e;
      int   w;
      cur = model(it);
      w   = (wait_n < 1) ? 1 : wait_n;
      #1;
      n_tests++;
      if (obs !== 8'b000_10000) begin
         n_fail++; $display("FAIL fetch_outputs it=%h got %b want %b", it, obs, 8'b000_10000);
      end
      ifu_ack = 1'b1; inst_type = it;
      sb_q.push_back(cur);
      #1;
      n_tests++;
      if (inst_wen !== 1'b1) begin
         n_fail++; $display("FAIL inst_wen it=%h got %b want 1", it, inst_wen);
      end
      @(negedge clk);
      ifu_ack = stray; lsu_ack = stray;
      #1;
      n_tests++;
      if ({obs, inst_wen} !== 9'b001_00000_0) begin
         n_fail++; $display("FAIL decode_outputs it=%h got %b want %b", it, {obs, inst_wen}, 9'b001_00000_0);
      end
      @(negedge clk);
      ifu_ack = 1'b0; lsu_ack = 1'b0;
      if (cur.mem) begin
         for (int k = 0; k < w; k++) begin
            #1;
            n_tests++;
            if (obs !== {3'd2, 1'b0, 1'b1, cur.we, 1'b0, 1'b0}) begin
               n_fail++; $display("FAIL mem_outputs it=%h k=%0d got %b want %b", it, k, obs,
                                  {3'd2, 1'b0, 1'b1, cur.we, 1'b0, 1'b0});
            end
            if (k == w - 1) lsu_ack = 1'b1;
            @(negedge clk);
            lsu_ack = 1'b0;
         end
      end
      #1;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++; $display("FAIL scoreboard_empty it=%h got 0 entries want 1", it);
      end else begin
         e = sb_q.pop_front();
         if (obs !== {3'd3, 1'b0, 1'b0, 1'b0, e.rw, 1'b1}) begin
            n_fail++; $display("FAIL wb_outputs it=%h got %b want %b", it, obs,
                               {3'd3, 1'b0, 1'b0, 1'b0, e.rw, 1'b1});
         end
      end
      exp_ret++;
      exp_cyc += 3 + (cur.mem ? w : 0);
      @(negedge clk);
      #1;
      n_tests++;
      if (instret !== exp_ret) begin
         n_fail++; $display("FAIL instret it=%h got %0d want %0d", it, instret, exp_ret);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ifu_ack = 1'b1; lsu_ack = 1'b1; inst_type = 32'h20;
      @(negedge clk);
      #1;
      n_tests++;
      if ({obs, inst_wen, halt, err} !== 12'b000_00000_0_0_00 || cycle_cnt !== 0 || instret !== 0) begin
         n_fail++; $display("FAIL reset_state got obs=%b iw=%b h=%b e=%b cyc=%0d ret=%0d want all zero",
                            obs, inst_wen, halt, err, cycle_cnt, instret);
      end
      ifu_ack = 1'b0; lsu_ack = 1'b0;
      rst = 1'b0;
      #1;
      n_tests++;
      if (ifu_req !== 1'b1) begin
         n_fail++; $display("FAIL first_ifu_req got %b want 1", ifu_req);
      end
   endtask

   task automatic test_addi();
      do_reset();
      run_inst(32'h1, 0, 1'b0);
      n_tests++;
      if (cycle_cnt !== 32'd3) begin
         n_fail++; $display("FAIL addi_cycle_cnt got %0d want 3", cycle_cnt);
      end
   endtask

   task automatic test_lw_slow();
      do_reset();
      run_inst(32'h20, 5, 1'b0);
      n_tests++;
      if (cycle_cnt !== 32'd8) begin
         n_fail++; $display("FAIL lw_cycle_cnt got %0d want 8", cycle_cnt);
      end
   endtask

   task automatic test_sw_beq();
      do_reset();
      run_inst(32'h80, 1, 1'b0);
      run_inst(32'h4000, 0, 1'b0);
      run_inst(32'h200000, 2, 1'b0);
   endtask

   task automatic test_stray();
      do_reset();
      run_inst(32'h40, 2, 1'b1);
      run_inst(32'h10, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 14; i++)
         run_inst(mix[$urandom_range(0, 9)], $urandom_range(1, 3), (i % 3) == 0);
      n_tests++;
      if (cycle_cnt !== exp_cyc) begin
         n_fail++; $display("FAIL b2b_cycle_cnt got %0d want %0d", cycle_cnt, exp_cyc);
      end
   endtask

   task automatic test_ebreak();
      do_reset();
      #1 ifu_ack = 1'b1; inst_type = 32'h4;
      @(negedge clk);
      ifu_ack = 1'b0;
      @(negedge clk);
      #1;
      n_tests++;
      if ({obs, halt, err} !== 11'b100_00000_1_00) begin
         n_fail++; $display("FAIL ebreak_entry got %b want %b", {obs, halt, err}, 11'b100_00000_1_00);
      end
      ifu_ack = 1'b1; lsu_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if ({obs, inst_wen, halt} !== 10'b100_00000_0_1 || cycle_cnt !== 32'd2) begin
            n_fail++; $display("FAIL ebreak_hold k=%0d got %b cyc=%0d want %b cyc=2",
                               k, {obs, inst_wen, halt}, cycle_cnt, 10'b100_00000_0_1);
         end
      end
      ifu_ack = 1'b0; lsu_ack = 1'b0;
   endtask

   task automatic test_illegal();
      do_reset();
      #1 ifu_ack = 1'b1; inst_type = 32'hFFFF_FFFF;
      @(negedge clk);
      ifu_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if ({obs, halt, err} !== 11'b101_00000_0_01) begin
            n_fail++; $display("FAIL illegal k=%0d got %b want %b", k, {obs, halt, err}, 11'b101_00000_0_01);
         end
      end
   endtask

   task automatic reset_b();
      rst_b = 1'b1; ifu_ack_b = 1'b0; lsu_ack_b = 1'b0; inst_type_b = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;
   endtask

   task automatic test_timeout();
      reset_b();
      for (int k = 0; k < 4; k++) begin
         #1;
         n_tests++;
         if (obs_b !== 8'b000_10000) begin
            n_fail++; $display("FAIL ifu_wait k=%0d got %b want %b", k, obs_b, 8'b000_10000);
         end
         @(negedge clk);
      end
      #1;
      n_tests++;
      if ({obs_b, err_b, halt_b} !== 11'b101_00000_10_0 || cycle_cnt_b !== 16'd4 || instret_b !== 16'd0) begin
         n_fail++; $display("FAIL ifu_timeout got %b cyc=%0d ret=%0d want %b cyc=4 ret=0",
                            {obs_b, err_b, halt_b}, cycle_cnt_b, instret_b, 11'b101_00000_10_0);
      end
      reset_b();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      ifu_ack_b = 1'b1; inst_type_b = 32'h40;
      #1;
      n_tests++;
      if (inst_wen_b !== 1'b1) begin
         n_fail++; $display("FAIL ack_on_limit_wen got %b want 1", inst_wen_b);
      end
      @(negedge clk);
      ifu_ack_b = 1'b0;
      #1;
      n_tests++;
      if ({state_b, err_b} !== 5'b001_00) begin
         n_fail++; $display("FAIL ack_on_limit got %b want %b", {state_b, err_b}, 5'b001_00);
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_tests++;
         if (obs_b !== 8'b010_01000) begin
            n_fail++; $display("FAIL lsu_wait k=%0d got %b want %b", k, obs_b, 8'b010_01000);
         end
         @(negedge clk);
      end
      #1;
      n_tests++;
      if ({obs_b, err_b} !== 10'b101_00000_11) begin
         n_fail++; $display("FAIL lsu_timeout got %b want %b", {obs_b, err_b}, 10'b101_00000_11);
      end
   endtask

   task automatic test_reset_mem();
      do_reset();
      run_inst(32'h1, 0, 1'b0);
      #1 ifu_ack = 1'b1; inst_type = 32'h100;
      @(negedge clk);
      ifu_ack = 1'b0;
      @(negedge clk);
      #1;
      n_tests++;
      if (obs !== 8'b010_01100) begin
         n_fail++; $display("FAIL pre_reset_mem got %b want %b", obs, 8'b010_01100);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_tests++;
      if (obs !== 8'b000_00000 || cycle_cnt !== 0 || instret !== 0) begin
         n_fail++; $display("FAIL reset_in_mem got %b cyc=%0d ret=%0d want 00000000 cyc=0 ret=0",
                            obs, cycle_cnt, instret);
      end
      rst = 1'b0;
      exp_ret = 0;
      exp_cyc = 0;
      run_inst(32'h8000, 0, 1'b0);
   endtask

   initial begin
      rst_b = 1'b1; ifu_ack_b = 1'b0; lsu_ack_b = 1'b0; inst_type_b = 32'h0;
      test_reset();
      test_addi();
      test_lw_slow();
      test_sw_beq();
      test_stray();
      test_back_to_back();
      test_ebreak();
      test_illegal();
      test_timeout();
      test_reset_mem();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit reached at %0t", $time);
      $fatal(1);
   end

endmodule
